// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the multi-cycle CPU.
// Latches jump/branch redirect targets during ID/EX and commits the new PC
// once per instruction on InstrDone. Trap has the highest priority.
// Optional feature: define PC_ALIGN_CHECK_EN to turn misaligned commits
// into traps that raise AlignFault.
module pc_sequencer #(
    parameter int               WIDTH       = 32,
    parameter int               STAGE_W     = 5,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0080)
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [STAGE_W-1:0] Stage,
    input  logic               Stall,
    input  logic               InstrDone,
    input  logic               Jump,
    input  logic               JumpReg,
    input  logic               Branch,
    input  logic [2:0]         BranchCond,
    input  logic               ZF,
    input  logic               SF,
    input  logic [WIDTH-1:0]   JumpPC,
    input  logic [WIDTH-1:0]   JumpRegPC,
    input  logic [WIDTH-1:0]   BranchPC,
    input  logic               Trap,
    output logic [WIDTH-1:0]   PC,
    output logic [WIDTH-1:0]   NextPC,
    output logic [WIDTH-1:0]   EPC,
    output logic               PCUpdate,
    output logic               Redirected,
    output logic               AlignFault
);

    // Exact one-hot codes: any other Stage value (zero, multi-hot) matches neither.
    localparam logic [STAGE_W-1:0] STAGE_ID = STAGE_W'(1) << (STAGE_W - 2);
    localparam logic [STAGE_W-1:0] STAGE_EX = STAGE_W'(1) << (STAGE_W - 3);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pc_update_q, pc_update_d;
    logic             redirected_q, redirected_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;
    logic             commit;
    logic             align_bad;
`ifdef PC_ALIGN_CHECK_EN
    logic             align_fault_q, align_fault_d;
`endif

    function automatic logic branch_taken(input logic [2:0] cond, input logic zf, input logic sf);
        case (cond)
            3'b000:  branch_taken = zf;
            3'b001:  branch_taken = !zf;
            3'b010:  branch_taken = sf;
            3'b011:  branch_taken = !sf;
            3'b100:  branch_taken = !sf && !zf;
            3'b101:  branch_taken = sf || zf;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Next-state: target capture, then commit/trap which clear the pending target.
    always_comb begin
        pc_plus4     = pc_q + WIDTH'(4);
        next_pc      = pend_vld_q ? pend_q : pc_plus4;
        commit       = InstrDone && !Stall && !Trap;
`ifdef PC_ALIGN_CHECK_EN
        align_bad    = commit && (next_pc[1:0] != 2'b00);
        align_fault_d = align_fault_q;
`else
        align_bad    = 1'b0;
`endif
        pc_d         = pc_q;
        epc_d        = epc_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        pc_update_d  = 1'b0;
        redirected_d = 1'b0;

        // Capture priority: JumpReg > Branch > Jump.
        if ((Stage == STAGE_EX) && JumpReg) begin
            pend_d     = JumpRegPC;
            pend_vld_d = 1'b1;
        end else if ((Stage == STAGE_EX) && Branch && branch_taken(BranchCond, ZF, SF)) begin
            pend_d     = BranchPC;
            pend_vld_d = 1'b1;
        end else if ((Stage == STAGE_ID) && Jump) begin
            pend_d     = JumpPC;
            pend_vld_d = 1'b1;
        end

        if (Trap || align_bad) begin
            epc_d        = pc_q;
            pc_d         = TRAP_VECTOR;
            pend_vld_d   = 1'b0;
            pc_update_d  = 1'b1;
            redirected_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (align_bad) begin
                align_fault_d = 1'b1;
            end
`endif
        end else if (commit) begin
            pc_d         = next_pc;
            pend_vld_d   = 1'b0;
            pc_update_d  = 1'b1;
            redirected_d = pend_vld_q;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_d = 1'b0;
`endif
        end
    end

    // State registers; reset also discards any pending target.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc_q         <= RESET_PC;
            epc_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            pc_update_q  <= 1'b0;
            redirected_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            pc_update_q  <= pc_update_d;
            redirected_q <= redirected_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky alignment fault flag, cleared by the next normal commit.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= align_fault_d;
        end
    end

    assign AlignFault = align_fault_q;
`else
    assign AlignFault = 1'b0;
`endif

    assign PC         = pc_q;
    assign NextPC     = next_pc;
    assign EPC        = epc_q;
    assign PCUpdate   = pc_update_q;
    assign Redirected = redirected_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the multi-cycle CPU; the next generation of the combinational next-PC selector.
- Owns the PC register and latches redirect targets during decode/execute.
- Commits the new PC once per instruction on a done strobe; adds stall, six branch conditions, register-indirect jump and a trap vector.
- Sits between the microcode controller (Stage, control bits) and instruction fetch.

Parameters:
- WIDTH, 32, PC and target width in bits (≥8).
- STAGE_W, 5, width of one-hot Stage bus: bit STAGE_W-1 = IF, STAGE_W-2 = ID, STAGE_W-3 = EX.
- RESET_PC, 32'h00000000, PC value after reset.
- TRAP_VECTOR, 32'h00000080, PC loaded on trap.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- Stage  in  STAGE_W  one-hot current stage.
- Stall  in  1  blocks commit only.
- InstrDone  in  1  instruction finished; commit PC this edge.
- Jump  in  1  direct jump, sampled in ID.
- JumpReg  in  1  register jump, sampled in EX.
- Branch  in  1  conditional branch, sampled in EX.
- BranchCond  in  3  000 BEQ, 001 BNE, 010 BLTZ, 011 BGEZ, 100 BGTZ, 101 BLEZ, 11x never.
- ZF  in  1  ALU zero flag.
- SF  in  1  ALU sign flag.
- JumpPC  in  WIDTH  direct jump target.
- JumpRegPC  in  WIDTH  register jump target.
- BranchPC  in  WIDTH  branch target.
- Trap  in  1  exception request.
- PC  out  WIDTH  current PC (registered).
- NextPC  out  WIDTH  combinational: value PC takes at next commit.
- EPC  out  WIDTH  PC of trapping instruction (registered).
- PCUpdate  out  1  registered one-cycle pulse after each PC write.
- Redirected  out  1  registered: last commit used a latched target.
- AlignFault  out  1  registered alignment fault flag (optional feature).

Behaviour:
- Reset: PC = RESET_PC, EPC = 0, pending target = 0, pending valid = 0. PCUpdate, Redirected and AlignFault = 0. Reset mid-instruction discards the pending target.
- PCPlus4 = PC + 4, modulo 2^WIDTH. PC = 2^WIDTH-4 wraps to 0.
- Branch taken table:
  - BEQ: ZF.
  - BNE: !ZF.
  - BLTZ: SF.
  - BGEZ: !SF.
  - BGTZ: !SF && !ZF.
  - BLEZ: SF || ZF.
- Capture (every edge, independent of Stall):
  - Stage==ID && Jump → pending = JumpPC, valid = 1.
  - Stage==EX && JumpReg → pending = JumpRegPC, valid = 1.
  - Stage==EX && Branch && taken → pending = BranchPC, valid = 1.
  - Same-cycle priority: JumpReg > Branch > Jump. A later capture overwrites an earlier one within the same instruction.
  - A non-one-hot or zero Stage captures nothing.
- NextPC = pending valid ? pending : PCPlus4. NextPC does not include same-cycle capture; the controller asserts InstrDone at least one cycle after the capture stage.
- Commit: on an edge with InstrDone && !Stall && !Trap:
  - PC ← NextPC.
  - pending valid ← 0.
  - PCUpdate ← 1.
  - Redirected ← old pending valid.
- Stall: InstrDone is ignored while Stall=1. PC and pending are held. Captures still occur.
- Trap (highest priority) on any edge:
  - EPC ← PC, PC ← TRAP_VECTOR.
  - pending valid ← 0.
  - PCUpdate ← 1, Redirected ← 1.
  - Trap overrides a simultaneous InstrDone and Stall.
- PCUpdate and Redirected are 0 on any edge with no PC write.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Enabled:
  - A commit whose NextPC[1:0] != 0 is converted to a trap: EPC ← PC, PC ← TRAP_VECTOR, AlignFault ← 1.
  - AlignFault clears on the next normal commit.
- Disabled: targets are used unmodified and AlignFault is tied to 0.

Test Plan:
- Reset with RSTn low mid-cycle, then release → PC = 0 immediately (async). InstrDone with no redirect → PC = 4, PCUpdate pulses one cycle, Redirected = 0.
- PC=0x10, Stage=ID, Jump=1, JumpPC=0x200, InstrDone next cycle → PC = 0x200, Redirected = 1.
- Stage=EX, Branch=1, BranchCond=BGTZ, BranchPC=0x40:
  - ZF=0, SF=0 → PC = 0x40.
  - Repeat with ZF=1 → PC = PC+4.
  - BranchCond=110 → never taken.
- JumpReg and Branch taken same EX cycle (targets 0x300 / 0x400) → PC = 0x300. Stall=1 with InstrDone for 3 cycles → PC held; commit after Stall drops.
- PC=0x1234, Trap with InstrDone and Stall=1 → PC = 0x80, EPC = 0x1234, pending cleared. PC = 0xFFFFFFFC plain commit → PC = 0.
- PC_ALIGN_CHECK_EN on: JumpPC=0x202 committed → PC = 0x80, AlignFault = 1. Feature off: PC = 0x202, AlignFault = 0.
